// File: rtl/mul_booth_seq.sv
// Iterative radix-4 Booth multiplier: one Booth digit per cycle, signed or unsigned operands,
// valid/ready handshake on both the operand and product sides.
module mul_booth_seq #(
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      valid_i,
   output logic                      ready_o,
   input  logic [DATA_WIDTH-1:0]     a_i,
   input  logic [DATA_WIDTH-1:0]     b_i,
   input  logic                      signed_i,
   output logic                      valid_o,
   input  logic                      ready_i,
   output logic [2*DATA_WIDTH-1:0]   product_o,
   output logic                      busy_o
);

   localparam int unsigned W     = DATA_WIDTH;
   localparam int unsigned XW    = W + 2;
   localparam int unsigned AW    = W + 4;
   localparam int unsigned NDig  = XW / 2;
   localparam int unsigned CntW  = (NDig > 1) ? $clog2(NDig) : 1;

   typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

   state_e              state_q;
   logic [XW-1:0]       x_q;
   logic [XW-1:0]       y_q;
   logic                y_prev_q;
   logic [AW-1:0]       acc_hi_q;
   logic [W-1:0]        acc_lo_q;
   logic [CntW-1:0]     cnt_q;
   logic [2*W-1:0]      product_q;

   logic [XW-1:0]       a_ext;
   logic [XW-1:0]       b_ext;
   logic [2:0]          digit;
   logic [AW-1:0]       x_ext;
   logic [AW-1:0]       mag;
   logic                neg;
   logic [AW-1:0]       sum;

   assign a_ext = signed_i ? {{2{a_i[W-1]}}, a_i} : {2'b00, a_i};
   assign b_ext = signed_i ? {{2{b_i[W-1]}}, b_i} : {2'b00, b_i};
   assign digit = {y_q[1:0], y_prev_q};

   // Booth recoding: select 0, X or 2X; negation is ones' complement plus carry-in.
   always_comb begin
      x_ext = {{2{x_q[XW-1]}}, x_q};
      mag   = '0;
      neg   = 1'b0;
      unique case (digit)
         3'b001, 3'b010: mag = x_ext;
         3'b011:         mag = x_ext << 1;
         3'b100: begin
            mag = x_ext << 1;
            neg = 1'b1;
         end
         3'b101, 3'b110: begin
            mag = x_ext;
            neg = 1'b1;
         end
         default: mag = '0;
      endcase
      sum = acc_hi_q + (neg ? ~mag : mag) + AW'(neg);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         x_q       <= '0;
         y_q       <= '0;
         y_prev_q  <= 1'b0;
         acc_hi_q  <= '0;
         acc_lo_q  <= '0;
         cnt_q     <= '0;
         product_q <= '0;
      end else begin
         case (state_q)
            StIdle: begin
               if (valid_i) begin
                  x_q      <= a_ext;
                  y_q      <= b_ext;
                  y_prev_q <= 1'b0;
                  acc_hi_q <= '0;
                  acc_lo_q <= '0;
                  cnt_q    <= CntW'(NDig - 1);
                  state_q  <= StBusy;
               end
            end
            StBusy: begin
               acc_hi_q <= {{2{sum[AW-1]}}, sum[AW-1:2]};
               acc_lo_q <= {sum[1:0], acc_lo_q[W-1:2]};
               y_q      <= {{2{y_q[XW-1]}}, y_q[XW-1:2]};
               y_prev_q <= y_q[1];
               if (cnt_q == '0) begin
                  // After N-1 shifts the low W product bits already sit in acc_lo.
                  product_q <= {sum[W-1:0], acc_lo_q};
                  state_q   <= StDone;
               end else begin
                  cnt_q <= cnt_q - CntW'(1);
               end
            end
            StDone: begin
               if (ready_i) state_q <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign ready_o   = (state_q == StIdle);
   assign busy_o    = (state_q == StBusy);
   assign valid_o   = (state_q == StDone);
   assign product_o = product_q;

endmodule

// File: tb/tb_mul_booth_seq.sv
// Scoreboard bench for mul_booth_seq: directed corner cases plus randomized operands checked
// against a plain-arithmetic reference product.
module tb_mul_booth_seq;

   localparam int W = 32;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            valid_i;
   logic            ready_o;
   logic [W-1:0]    a_i;
   logic [W-1:0]    b_i;
   logic            signed_i;
   logic            valid_o;
   logic            ready_i = 1'b1;
   logic [2*W-1:0]  product_o;
   logic            busy_o;

   always #5 clk = ~clk;

   mul_booth_seq #(.DATA_WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .valid_i   (valid_i),
      .ready_o   (ready_o),
      .a_i       (a_i),
      .b_i       (b_i),
      .signed_i  (signed_i),
      .valid_o   (valid_o),
      .ready_i   (ready_i),
      .product_o (product_o),
      .busy_o    (busy_o)
   );

   int          n_checks   = 0;
   int          n_pass     = 0;
   int          n_in       = 0;
   int          n_out      = 0;
   int          ready_mode = 0;  // 0: ready held high, 1: random stalls, 2: driven by main
   logic [63:0] exp_q[$];

   function automatic logic [63:0] ref_mul(logic [31:0] a, logic [31:0] b, logic s);
      longint sa, sb;
      if (s) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
         return 64'(sa * sb);
      end
      return {32'b0, a} * {32'b0, b};
   endfunction

   function automatic logic [31:0] pick_op();
      case ($urandom_range(0, 7))
         0:       return 32'h0000_0000;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return 32'h7FFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   task automatic check(string name, logic [63:0] act, logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
   endtask

   // Output monitor: pops the scoreboard on every product handshake.
   always @(negedge clk) begin
      if (ready_mode == 0) ready_i = 1'b1;
      else if (ready_mode == 1) ready_i = ($urandom_range(0, 3) != 0);
      if (rst_n && valid_o && ready_i) begin
         n_out++;
         if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_output: got 0x%h with empty scoreboard", product_o);
         end else begin
            check("product", product_o, exp_q.pop_front());
         end
      end
   end

   // Called at posedge+1; drives junk requests while the block is not ready.
   task automatic issue(logic [31:0] a, logic [31:0] b, logic s);
      int guard = 0;
      while (!ready_o && guard < 1000) begin
         valid_i  = 1'($urandom_range(0, 1));
         a_i      = $urandom;
         b_i      = $urandom;
         signed_i = 1'($urandom_range(0, 1));
         @(posedge clk); #1;
         guard++;
      end
      check("issue_ready", 64'(ready_o), 64'd1);
      valid_i  = 1'b1;
      a_i      = a;
      b_i      = b;
      signed_i = s;
      exp_q.push_back(ref_mul(a, b, s));
      n_in++;
      @(posedge clk); #1;
      valid_i = 1'b0;
   endtask

   task automatic drain();
      int guard = 0;
      while (exp_q.size() != 0 && guard < 2000) begin
         @(posedge clk); #1;
         guard++;
      end
      check("drain", 64'(exp_q.size()), 64'd0);
   endtask

   task automatic run_op(logic [31:0] a, logic [31:0] b, logic s, string name);
      int lat;
      int nbusy;
      issue(a, b, s);
      lat   = 0;
      nbusy = busy_o ? 1 : 0;
      while (!valid_o && lat < 100) begin
         valid_i  = 1'($urandom_range(0, 1));
         a_i      = $urandom;
         b_i      = $urandom;
         signed_i = 1'($urandom_range(0, 1));
         @(posedge clk); #1;
         lat++;
         if (busy_o) nbusy++;
      end
      valid_i = 1'b0;
      check({name, "_latency"}, 64'(lat), 64'd17);
      check({name, "_busy_cycles"}, 64'(nbusy), 64'd17);
      drain();
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int guard;
      rst_n    = 1'b0;
      valid_i  = 1'b0;
      a_i      = '0;
      b_i      = '0;
      signed_i = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      check("reset_ready", 64'(ready_o), 64'd1);
      check("reset_valid", 64'(valid_o), 64'd0);
      check("reset_busy", 64'(busy_o), 64'd0);
      check("reset_product", product_o, 64'd0);

      // Directed: results checked by the monitor, latency checked here.
      run_op(32'd3, 32'hFFFF_FFFB, 1'b1, "signed_basic");
      check("signed_basic_value", product_o, 64'hFFFF_FFFF_FFFF_FFF1);
      run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "unsigned_max");
      check("unsigned_max_value", product_o, 64'hFFFF_FFFE_0000_0001);
      run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, "signed_m1");
      check("signed_m1_value", product_o, 64'h0000_0000_0000_0001);
      run_op(32'h8000_0000, 32'h8000_0000, 1'b1, "signed_min_sq");
      check("signed_min_sq_value", product_o, 64'h4000_0000_0000_0000);
      run_op(32'h7FFF_FFFF, 32'h8000_0000, 1'b1, "max_x_min");
      check("max_x_min_value", product_o, 64'hC000_0000_8000_0000);
      run_op(32'hDEAD_BEEF, 32'h0, 1'b1, "times_zero_s");
      run_op(32'h0, 32'hFFFF_FFFF, 1'b0, "zero_times_u");

      // Backpressure: hold ready_i low in DONE.
      ready_mode = 2;
      ready_i    = 1'b0;
      issue(32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
      guard = 0;
      while (!valid_o && guard < 100) begin
         @(posedge clk); #1;
         guard++;
      end
      for (int i = 0; i < 5; i++) begin
         check("bp_valid", 64'(valid_o), 64'd1);
         check("bp_product", product_o, ref_mul(32'h1234_5678, 32'h9ABC_DEF0, 1'b0));
         check("bp_ready_low", 64'(ready_o), 64'd0);
         @(posedge clk); #1;
      end
      ready_i = 1'b1;
      check("bp_ready_before_hs", 64'(ready_o), 64'd0);
      @(posedge clk); #1;
      check("bp_ready_after_hs", 64'(ready_o), 64'd1);
      check("bp_valid_after_hs", 64'(valid_o), 64'd0);
      ready_mode = 0;
      drain();

      // Reset at the 8th BUSY cycle discards the operation.
      issue(32'hCAFE_F00D, 32'h0BAD_BEEF, 1'b1);
      repeat (7) begin
         @(posedge clk); #1;
      end
      check("rst_mid_busy", 64'(busy_o), 64'd1);
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      void'(exp_q.pop_back());
      n_in--;
      check("rst_mid_ready", 64'(ready_o), 64'd1);
      check("rst_mid_valid", 64'(valid_o), 64'd0);
      check("rst_mid_product", product_o, 64'd0);
      run_op(32'd7, 32'd6, 1'b0, "after_reset");
      check("after_reset_value", product_o, 64'd42);

      // Random regression with stalls and input gaps.
      ready_mode = 1;
      for (int i = 0; i < 1200; i++) begin
         valid_i = 1'b0;
         repeat ($urandom_range(0, 3)) begin
            @(posedge clk); #1;
         end
         issue(pick_op(), pick_op(), 1'($urandom_range(0, 1)));
      end
      ready_mode = 0;
      drain();
      check("ops_in_equals_out", 64'(n_out), 64'(n_in));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
